// File: rtl/inhibit_event_counter.sv
// inhibit_event_counter: input synchroniser, z = a & ~b qualification FSM,
// rising-event counter with sticky saturation, and a valid/ready count
// snapshot port.
// Optional feature macro: INHIBIT_DEBOUNCE_EN. When it is defined, z must
// hold for DEBOUNCE_CYCLES consecutive samples before z_out follows it.
// When it is undefined, the FSM toggles LOW<->HIGH directly.
`timescale 1ns/1ps

module inhibit_event_counter #(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             z_out,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_data
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    QUAL_HI = 2'd1,
    HIGH    = 2'd2,
    QUAL_LO = 2'd3
  } zState_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  zState_t state;
  logic    aMeta;
  logic    aSync;
  logic    bMeta;
  logic    bSync;
  logic    zRaw;
  logic    riseEvt;

  // Two-flop synchronisers for the asynchronous gate inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aMeta <= 1'b0;
      aSync <= 1'b0;
      bMeta <= 1'b0;
      bSync <= 1'b0;
    end else begin
      aMeta <= a_in;
      aSync <= aMeta;
      bMeta <= b_in;
      bSync <= bMeta;
    end
  end

  assign zRaw = aSync & ~bSync;

`ifdef INHIBIT_DEBOUNCE_EN
  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit              DB_ONE  = (DEBOUNCE_CYCLES == 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_INIT = DB_W'(1);

  logic [DB_W-1:0] dbCnt;

  // Entering the qualifying state counts as the first matching sample, so
  // the transition fires once dbCnt has reached DEBOUNCE_CYCLES-1 and the
  // current sample still matches.
  always_comb begin
    riseEvt = 1'b0;
    if (zRaw) begin
      if (state == LOW && DB_ONE) begin
        riseEvt = 1'b1;
      end else if (state == QUAL_HI && dbCnt >= DB_LAST) begin
        riseEvt = 1'b1;
      end
    end
  end

  // Qualification FSM with debounce counter and registered z_out/evt_pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOW;
      dbCnt     <= '0;
      z_out     <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      evt_pulse <= riseEvt;
      case (state)
        LOW: begin
          if (zRaw) begin
            if (DB_ONE) begin
              state <= HIGH;
              z_out <= 1'b1;
            end else begin
              state <= QUAL_HI;
              dbCnt <= DB_INIT;
            end
          end
        end
        QUAL_HI: begin
          if (!zRaw) begin
            state <= LOW;
            dbCnt <= '0;
          end else if (dbCnt >= DB_LAST) begin
            state <= HIGH;
            dbCnt <= '0;
            z_out <= 1'b1;
          end else begin
            dbCnt <= dbCnt + 1'b1;
          end
        end
        HIGH: begin
          if (!zRaw) begin
            if (DB_ONE) begin
              state <= LOW;
              z_out <= 1'b0;
            end else begin
              state <= QUAL_LO;
              dbCnt <= DB_INIT;
            end
          end
        end
        QUAL_LO: begin
          if (zRaw) begin
            state <= HIGH;
            dbCnt <= '0;
          end else if (dbCnt >= DB_LAST) begin
            state <= LOW;
            dbCnt <= '0;
            z_out <= 1'b0;
          end else begin
            dbCnt <= dbCnt + 1'b1;
          end
        end
      endcase
    end
  end
`else
  // Without debounce the only entry into HIGH is directly from LOW
  always_comb begin
    riseEvt = 1'b0;
    if (zRaw && state == LOW) begin
      riseEvt = 1'b1;
    end
  end

  // Direct LOW<->HIGH FSM with registered z_out/evt_pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOW;
      z_out     <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      evt_pulse <= riseEvt;
      case (state)
        LOW: begin
          if (zRaw) begin
            state <= HIGH;
            z_out <= 1'b1;
          end
        end
        HIGH: begin
          if (!zRaw) begin
            state <= LOW;
            z_out <= 1'b0;
          end
        end
        default: begin
          state <= LOW;
          z_out <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Event counter: clear wins over a same-cycle event, and the count holds at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (riseEvt) begin
      if (count == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        count <= count + 1'b1;
        if (count == CNT_MAX - 1'b1) begin
          sat <= 1'b1;
        end
      end
    end
  end

  // Snapshot holding register; new requests are ignored while a snapshot is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else if (snap_valid) begin
      if (snap_ready) begin
        snap_valid <= 1'b0;
      end
    end else if (snap_req) begin
      snap_valid <= 1'b1;
      snap_data  <= count;
    end
  end

endmodule

// File: tb/tb_inhibit_event_counter.sv
// Directed self-checking bench for inhibit_event_counter (CNT_W=4).
`timescale 1ns/1ps

module tb_inhibit_event_counter;

  localparam int unsigned CNT_W = 4;
`ifdef INHIBIT_DEBOUNCE_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk;
  logic             rst_n;
  logic             a_in;
  logic             b_in;
  logic             clear;
  logic             snap_req;
  logic             snap_ready;
  logic             z_out;
  logic             evt_pulse;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             snap_valid;
  logic [CNT_W-1:0] snap_data;

  int unsigned total;
  int unsigned bad;
  int unsigned expCount;

  inhibit_event_counter #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .clear     (clear),
    .snap_req  (snap_req),
    .snap_ready(snap_ready),
    .z_out     (z_out),
    .evt_pulse (evt_pulse),
    .count     (count),
    .sat       (sat),
    .snap_valid(snap_valid),
    .snap_data (snap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full z pulse: high long enough to qualify, then low long enough to return to LOW
  task automatic doEvent;
    a_in = 1'b1;
    b_in = 1'b0;
    repeat (LAT) tick();
    a_in = 1'b0;
    repeat (LAT) tick();
    if (expCount != 15) expCount++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (z_out !== 1'b0) begin bad++; $display("FAIL rst_z_out got=%0b exp=0", z_out); end
    total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL rst_evt got=%0b exp=0", evt_pulse); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%0b exp=0", sat); end
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL rst_snap_valid got=%0b exp=0", snap_valid); end
    total++; if (snap_data !== 4'd0) begin bad++; $display("FAIL rst_snap_data got=%0d exp=0", snap_data); end
    rst_n = 1'b1;
    tick();
    expCount = 0;
  endtask

  task automatic test_basic;
    a_in = 1'b1;
    b_in = 1'b0;
    repeat (LAT - 1) tick();
    total++; if (z_out !== 1'b0) begin bad++; $display("FAIL basic_early_z got=%0b exp=0", z_out); end
    tick();
    expCount++;
    total++; if (z_out !== 1'b1) begin bad++; $display("FAIL basic_z_rise got=%0b exp=1", z_out); end
    total++; if (evt_pulse !== 1'b1) begin bad++; $display("FAIL basic_evt got=%0b exp=1", evt_pulse); end
    total++; if (count !== expCount[CNT_W-1:0]) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", count, expCount); end
    tick();
    total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL basic_evt_one_cycle got=%0b exp=0", evt_pulse); end
    b_in = 1'b1;
    repeat (LAT - 1) tick();
    total++; if (z_out !== 1'b1) begin bad++; $display("FAIL basic_early_fall got=%0b exp=1", z_out); end
    tick();
    total++; if (z_out !== 1'b0) begin bad++; $display("FAIL basic_z_fall got=%0b exp=0", z_out); end
    total++; if (count !== expCount[CNT_W-1:0]) begin bad++; $display("FAIL basic_count_hold got=%0d exp=%0d", count, expCount); end
    a_in = 1'b0;
    b_in = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_glitch;
    logic zSeen;
    logic expSeen;
    zSeen = 1'b0;
    a_in = 1'b1;
    tick();
    tick();
    a_in = 1'b0;
    repeat (10) begin
      tick();
      zSeen = zSeen | z_out;
    end
`ifdef INHIBIT_DEBOUNCE_EN
    expSeen = 1'b0;
`else
    expSeen = 1'b1;
    expCount++;
`endif
    total++; if (zSeen !== expSeen) begin bad++; $display("FAIL glitch_z got=%0b exp=%0b", zSeen, expSeen); end
    total++; if (count !== expCount[CNT_W-1:0]) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", count, expCount); end
  endtask

  task automatic test_saturation;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expCount = 0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL sat_clear0 got=%0d exp=0", count); end
    repeat (14) doEvent();
    total++; if (count !== 4'd14) begin bad++; $display("FAIL sat_count14 got=%0d exp=14", count); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL sat_early got=%0b exp=0", sat); end
    doEvent();
    total++; if (count !== 4'd15) begin bad++; $display("FAIL sat_count15 got=%0d exp=15", count); end
    total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_set got=%0b exp=1", sat); end
    doEvent();
    total++; if (count !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", count); end
    total++; if (sat !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%0b exp=1", sat); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expCount = 0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL sat_clear_count got=%0d exp=0", count); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL sat_clear_sat got=%0b exp=0", sat); end
  endtask

  task automatic test_snapshot;
    int unsigned holdBad;
    holdBad = 0;
    repeat (7) doEvent();
    snap_req   = 1'b1;
    snap_ready = 1'b0;
    tick();
    snap_req = 1'b0;
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL snap_valid got=%0b exp=1", snap_valid); end
    total++; if (snap_data !== 4'd7) begin bad++; $display("FAIL snap_data got=%0d exp=7", snap_data); end
    for (int k = 0; k < 2; k++) begin
      a_in = 1'b1;
      for (int j = 0; j < 2 * LAT; j++) begin
        if (j == LAT) a_in = 1'b0;
        tick();
        if (snap_valid !== 1'b1 || snap_data !== 4'd7) holdBad++;
      end
    end
    expCount += 2;
    total++; if (holdBad != 0) begin bad++; $display("FAIL snap_hold got=%0d bad cycles exp=0", holdBad); end
    total++; if (count !== 4'd9) begin bad++; $display("FAIL snap_live_count got=%0d exp=9", count); end
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL snap_done got=%0b exp=0", snap_valid); end
  endtask

  task automatic test_back_to_back;
    a_in = 1'b1;
    b_in = 1'b0;
    repeat (LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expCount = 0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL clrevt_count got=%0d exp=0", count); end
    total++; if (evt_pulse !== 1'b1) begin bad++; $display("FAIL clrevt_evt got=%0b exp=1", evt_pulse); end
    total++; if (z_out !== 1'b1) begin bad++; $display("FAIL clrevt_z got=%0b exp=1", z_out); end
    a_in = 1'b0;
    repeat (LAT) tick();
    doEvent();
    doEvent();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    total++; if (snap_data !== 4'd2) begin bad++; $display("FAIL b2b_snap got=%0d exp=2", snap_data); end
    doEvent();
    snap_req = 1'b1;
    tick();
    total++; if (snap_data !== 4'd2) begin bad++; $display("FAIL b2b_req_ignored got=%0d exp=2", snap_data); end
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL b2b_complete got=%0b exp=0", snap_valid); end
    tick();
    snap_req = 1'b0;
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL b2b_recapture_v got=%0b exp=1", snap_valid); end
    total++; if (snap_data !== 4'd3) begin bad++; $display("FAIL b2b_recapture_d got=%0d exp=3", snap_data); end
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    doEvent();
    doEvent();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    total++; if (count !== 4'd5) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=5", count); end
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b exp=1", snap_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", snap_valid); end
    total++; if (snap_data !== 4'd0) begin bad++; $display("FAIL rmid_data got=%0d exp=0", snap_data); end
    total++; if (sat !== 1'b0 || z_out !== 1'b0 || evt_pulse !== 1'b0) begin
      bad++; $display("FAIL rmid_flags got=%0b%0b%0b exp=000", sat, z_out, evt_pulse);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    expCount = 0;
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL rmid_post_valid got=%0b exp=0", snap_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_post_count got=%0d exp=0", count); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    expCount   = 0;
    rst_n      = 1'b0;
    a_in       = 1'b0;
    b_in       = 1'b0;
    clear      = 1'b0;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_saturation();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
